// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Turns the flat hps_io ioctl byte stream into per-region ROM write strobes
//   and holds the core in reset until a complete download has landed and a
//   reset-hold period has elapsed.
//
// Ports
//   clk_sys, reset_n      clock, async active-low reset
//   dn_download/dn_wr     ioctl transfer level and byte-valid strobe
//   dn_addr/dn_data       ioctl byte address (17b) and byte
//   soft_reset            OSD/button reset request (level)
//   rom_we[3:0]           one-hot region strobe: CPU, GFX0, GFX1, sound/PROM
//   rom_addr/rom_data     region-local address and byte, valid with rom_we
//   core_reset_n          active-low core reset, high only in RUN
//   loaded                a non-empty download has completed since reset
//   busy                  LOAD or HOLD
//   oob_err               sticky per download: a write at/above ROM_END was dropped
//   byte_count            bytes accepted in current/last download (saturating)

// Single-region address decoder: range hit and region-local offset.
module rom_region_dec #(
  parameter logic [16:0] LO     = 17'h00000,
  parameter logic [16:0] HI     = 17'h06000,
  parameter bit          HAS_LO = 1'b1
) (
  input  logic [16:0] addr_i,
  output logic        hit_o,
  output logic [15:0] off_o
);
  // Region 0 starts at 0; skipping the lower compare avoids an always-true test.
  if (HAS_LO) begin : g_lo
    assign hit_o = (addr_i >= LO) && (addr_i < HI);
  end else begin : g_nolo
    assign hit_o = (addr_i < HI);
  end

  // Regions are at most 64 KiB, so the truncated difference is the local address.
  assign off_o = 16'(addr_i - LO);
endmodule

module rom_load_sequencer #(
  parameter logic [16:0] BASE1    = 17'h06000,
  parameter logic [16:0] BASE2    = 17'h08000,
  parameter logic [16:0] BASE3    = 17'h0A000,
  parameter logic [16:0] ROM_END  = 17'h0C000,
  parameter int          RST_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [16:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        soft_reset,
  output logic [3:0]  rom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset_n,
  output logic        loaded,
  output logic        busy,
  output logic        oob_err,
  output logic [16:0] byte_count
);
  localparam int NREG = 4;
  localparam int HCW  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_INIT = HCW'(RST_HOLD - 1);
  // Region boundaries: region r spans [EDGE[r], EDGE[r+1]).
  localparam logic [NREG:0][16:0] EDGE = {ROM_END, BASE3, BASE2, BASE1, 17'h00000};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [3:0]       we_q, we_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             core_rn_q, core_rn_d;
  logic             loaded_q, loaded_d;
  logic             busy_q, busy_d;
  logic             oob_q, oob_d;
  logic [16:0]      cnt_q, cnt_d;

  // ---------------- address decode ----------------
  logic [NREG-1:0]        hit;
  logic [NREG-1:0][15:0]  off;
  logic [15:0]            off_sel;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    rom_region_dec #(
      .LO    (EDGE[r]),
      .HI    (EDGE[r+1]),
      .HAS_LO(r != 0)
    ) u_dec (
      .addr_i(dn_addr),
      .hit_o (hit[r]),
      .off_o (off[r])
    );
  end

  always_comb begin
    off_sel = '0;
    for (int r = 0; r < NREG; r++)
      if (hit[r]) off_sel = off[r];
  end

  // A byte is taken whenever the transfer level is high, regardless of state,
  // so the very first cycle of a download (still IDLE/HOLD/RUN) counts too.
  logic accept, wr_ok, wr_oob, dl_start;
  logic [16:0] cnt_base;

  assign accept   = dn_download & dn_wr;
  assign wr_ok    = accept & (|hit);
  assign wr_oob   = accept & ~(|hit);
  assign dl_start = dn_download & (state_q != S_LOAD);
  assign cnt_base = dl_start ? 17'h0 : cnt_q;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: if (dn_download) state_d = S_LOAD;
      S_LOAD: begin
        if (!dn_download)
          state_d = ((cnt_q != 17'h0) || loaded_q) ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (dn_download)          state_d = S_LOAD;
        else if (soft_reset)      hold_d  = HOLD_INIT;
        else if (hold_q == '0)    state_d = S_RUN;
        else                      hold_d  = hold_q - HCW'(1);
      end
      S_RUN: begin
        if (dn_download)          state_d = S_LOAD;
        else if (soft_reset)      state_d = S_HOLD;
      end
    endcase
    if ((state_q != S_HOLD) && (state_d == S_HOLD)) hold_d = HOLD_INIT;
  end

  // ---------------- datapath / status next-state ----------------
  always_comb begin
    we_d      = wr_ok ? hit : 4'b0;
    addr_d    = wr_ok ? off_sel : addr_q;
    data_d    = wr_ok ? dn_data : data_q;
    cnt_d     = (wr_ok && (cnt_base != 17'h1FFFF)) ? cnt_base + 17'd1 : cnt_base;
    oob_d     = (dl_start ? 1'b0 : oob_q) | wr_oob;
    loaded_d  = loaded_q | ((state_q == S_LOAD) && (state_d == S_HOLD));
    // Driven from next state so the output tracks the state register exactly.
    core_rn_d = (state_d == S_RUN);
    busy_d    = (state_d == S_LOAD) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      we_q      <= 4'b0;
      addr_q    <= 16'h0;
      data_q    <= 8'h0;
      core_rn_q <= 1'b0;
      loaded_q  <= 1'b0;
      busy_q    <= 1'b0;
      oob_q     <= 1'b0;
      cnt_q     <= 17'h0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      core_rn_q <= core_rn_d;
      loaded_q  <= loaded_d;
      busy_q    <= busy_d;
      oob_q     <= oob_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rom_we       = we_q;
  assign rom_addr     = addr_q;
  assign rom_data     = data_q;
  assign core_reset_n = core_rn_q;
  assign loaded       = loaded_q;
  assign busy         = busy_q;
  assign oob_err      = oob_q;
  assign byte_count   = cnt_q;
endmodule

// File: tb/tb_rom_load_sequencer.sv
// Bench for rom_load_sequencer: a reference model predicts every region strobe
// into a queue, an independent negedge monitor drains it as strobes appear, and
// status/timing outputs are compared against the model at chosen points.
module tb_rom_load_sequencer;
  localparam int R = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dn_download = 1'b0, dn_wr = 1'b0, soft_reset = 1'b0;
  logic [16:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic [3:0]  rom_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset_n, loaded, busy, oob_err;
  logic [16:0] byte_count;

  rom_load_sequencer dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .soft_reset(soft_reset),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
    .core_reset_n(core_reset_n), .loaded(loaded), .busy(busy),
    .oob_err(oob_err), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0, n_err = 0;

  // ---------------- reference model ----------------
  logic [27:0] sb[$];
  logic [16:0] mdl_cnt = '0;
  bit          mdl_oob = 0, mdl_loaded = 0, prev_dl = 0;

  task automatic model_wr(input logic [16:0] a, input logic [7:0] d);
    logic [3:0]  we;
    logic [16:0] base;
    if (a >= 17'h0C000) begin
      mdl_oob = 1;
    end else begin
      if      (a < 17'h06000) begin we = 4'b0001; base = 17'h00000; end
      else if (a < 17'h08000) begin we = 4'b0010; base = 17'h06000; end
      else if (a < 17'h0A000) begin we = 4'b0100; base = 17'h08000; end
      else                    begin we = 4'b1000; base = 17'h0A000; end
      sb.push_back({we, 16'(a - base), d});
      if (mdl_cnt != 17'h1FFFF) mdl_cnt = mdl_cnt + 17'd1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [27:0] mon_exp;
  always @(negedge clk_sys) begin
    if (rom_we !== 4'b0) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected: got we=%b addr=%h data=%h expected none",
                 rom_we, rom_addr, rom_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({rom_we, rom_addr, rom_data} !== mon_exp) begin
          n_err++;
          $display("FAIL strobe: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                   rom_we, rom_addr, rom_data, mon_exp[27:24], mon_exp[23:8], mon_exp[7:0]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive_cycle(input bit dl, input bit wr, input logic [16:0] a,
                             input logic [7:0] d, input bit sr);
    dn_download = dl; dn_wr = wr; dn_addr = a; dn_data = d; soft_reset = sr;
    if (dl && !prev_dl) begin mdl_cnt = '0; mdl_oob = 0; end
    if (!dl && prev_dl && mdl_cnt != 0) mdl_loaded = 1;
    if (dl && wr) model_wr(a, d);
    prev_dl = dl;
    tick();
  endtask

  // Drops the transfer level; caller then counts edges.
  task automatic fall();
    dn_download = 0; dn_wr = 0; soft_reset = 0;
    if (prev_dl && mdl_cnt != 0) mdl_loaded = 1;
    prev_dl = 0;
  endtask

  task automatic wait_core_high(output int k);
    k = 0;
    while (core_reset_n !== 1'b1 && k < 200) begin tick(); k++; end
  endtask

  task automatic measure_low(input int rep, output int n);
    soft_reset = 1; tick(); soft_reset = 0;
    check("soft_next_cycle_low", {31'b0, core_reset_n}, 32'd0);
    n = 0;
    while (core_reset_n === 1'b0 && n < 200) begin
      n++;
      if (n == rep) soft_reset = 1;
      tick();
      soft_reset = 0;
    end
  endtask

  int k, n, len, gap;

  initial begin
    // ---- reset values ----
    #2;
    check("rst_we",     {28'b0, rom_we}, 0);
    check("rst_addr",   {16'b0, rom_addr}, 0);
    check("rst_data",   {24'b0, rom_data}, 0);
    check("rst_core",   {31'b0, core_reset_n}, 0);
    check("rst_loaded", {31'b0, loaded}, 0);
    check("rst_busy",   {31'b0, busy}, 0);
    check("rst_oob",    {31'b0, oob_err}, 0);
    check("rst_cnt",    {15'b0, byte_count}, 0);
    tick(); tick();
    reset_n = 1;
    tick();

    // ---- empty download from reset ----
    drive_cycle(1, 0, '0, '0, 0);
    drive_cycle(1, 0, '0, '0, 0);
    check("empty_busy_load", {31'b0, busy}, 1);
    drive_cycle(1, 1'b0, '0, '0, 0);
    fall();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        check("empty_loaded", {31'b0, loaded}, 0);
        check("empty_busy",   {31'b0, busy}, 0);
        check("empty_core",   {31'b0, core_reset_n}, 0);
      end
    end

    // ---- directed write, out-of-bounds, soft reset ignored in LOAD ----
    drive_cycle(1, 0, '0, '0, 0);
    drive_cycle(1, 1, 17'h08005, 8'hA5, 0);
    check("dir_strobe", {4'b0, rom_we, rom_addr, rom_data}, {4'b0, 4'b0100, 16'h0005, 8'hA5});
    drive_cycle(1, 1, 17'h0C000, 8'h11, 1);
    check("oob_set", {31'b0, oob_err}, 1);
    check("oob_cnt_unchanged", {15'b0, byte_count}, 1);
    drive_cycle(1, 0, '0, '0, 1);
    check("soft_in_load_busy", {31'b0, busy}, 1);
    check("soft_in_load_core", {31'b0, core_reset_n}, 0);
    drive_cycle(1, 0, '0, '0, 0);
    fall();
    wait_core_high(k);
    check("hold_len_dir", k, R + 1);
    check("loaded_dir", {31'b0, loaded}, 1);

    // ---- full load 0x0000..0xBFFF, starting from RUN ----
    drive_cycle(1, 1, 17'h00000, 8'(32'h0 * 7 + 3), 0);
    check("oob_cleared", {31'b0, oob_err}, 0);
    check("full_first_cnt", {15'b0, byte_count}, 1);
    for (int a = 1; a < 'hC000; a++)
      drive_cycle(1, 1, 17'(a), 8'(a * 7 + 3), 0);
    fall();
    wait_core_high(k);
    check("hold_len_full", k, R + 1);
    check("full_cnt", {15'b0, byte_count}, 32'h0C000);
    check("full_loaded", {31'b0, loaded}, 1);
    check("full_busy", {31'b0, busy}, 0);

    // ---- soft reset in RUN, then with extension in HOLD ----
    measure_low(0, n);
    check("soft_low_len", n, R);
    measure_low(5, n);
    check("soft_extend_len", n, R + 5);

    // ---- randomized downloads, some re-entered from HOLD ----
    for (int d = 0; d < 8; d++) begin
      len = $urandom_range(20, 80);
      for (int i = 0; i < len; i++)
        drive_cycle(1, $urandom_range(0, 3) != 0, 17'($urandom_range(0, 'hD000)),
                    8'($urandom), (i > 0 && i < len - 1) ? $urandom_range(0, 1) : 0);
      fall();
      gap = $urandom_range(1, 25);
      for (int g = 0; g < gap; g++) begin
        drive_cycle(0, $urandom_range(0, 1), 17'($urandom_range(0, 'hBFFF)), 8'($urandom), 0);
        if (g == 0) begin
          check("rnd_cnt", {15'b0, byte_count}, {15'b0, mdl_cnt});
          check("rnd_oob", {31'b0, oob_err}, {31'b0, mdl_oob});
          check("rnd_loaded", {31'b0, loaded}, {31'b0, mdl_loaded});
        end
      end
      check("rnd_core", {31'b0, core_reset_n}, {31'b0, gap > R});
    end

    // ---- reset mid-LOAD ----
    drive_cycle(1, 1, 17'h0C001, 8'h22, 0);
    drive_cycle(1, 1, 17'h09000, 8'h33, 0);
    drive_cycle(1, 0, '0, '0, 0);
    reset_n = 0;
    dn_download = 0; prev_dl = 0; mdl_loaded = 0; mdl_cnt = '0; mdl_oob = 0;
    #1;
    check("mid_rst_cnt",    {15'b0, byte_count}, 0);
    check("mid_rst_oob",    {31'b0, oob_err}, 0);
    check("mid_rst_loaded", {31'b0, loaded}, 0);
    check("mid_rst_busy",   {31'b0, busy}, 0);
    check("mid_rst_addr",   {16'b0, rom_addr}, 0);
    check("mid_rst_data",   {24'b0, rom_data}, 0);
    sb.delete();
    tick(); tick();
    reset_n = 1;
    tick();
    drive_cycle(1, 1, 17'h0A003, 8'h77, 0);
    drive_cycle(1, 1, 17'h05FFF, 8'h88, 0);
    fall();
    wait_core_high(k);
    check("hold_len_after_rst", k, R + 1);
    check("after_rst_cnt", {15'b0, byte_count}, 2);
    check("after_rst_loaded", {31'b0, loaded}, 1);

    tick(); tick();
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
